alu_share_arbiter: RTL

Round-robin arbiter and sequencer that shares one registered 16-bit add/subtract unit among several requesters. It sits between client blocks and the arithmetic datapath, built from the same adder/subtractor functions as `full_adder` and `subtract_16_bit`. For each request it grants access, captures the operands and returns a tagged result.

---
 rtl/alu_share_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter sharing one registered add/subtract unit
// Optional saturating arithmetic: define ALU_ARB_SAT_EN.
module alu_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         op,
    input  logic [N_REQ*WIDTH-1:0]   a_bus,
    input  logic [N_REQ*WIDTH-1:0]   b_bus,
    output logic [N_REQ-1:0]         gnt,
    output logic [WIDTH-1:0]         res,
    output logic                     flag,
    output logic                     res_valid,
    output logic [$clog2(N_REQ)-1:0] res_id,
    output logic                     busy
);
    localparam int IDW = $clog2(N_REQ);
    localparam logic [IDW-1:0] LAST_RST = IDW'(N_REQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_GNT, S_EXEC, S_DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   last;
    logic [IDW-1:0]   cur_idx;
    logic [IDW-1:0]   win_idx;
    logic             win_found;
    logic             arb_take;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             op_q;
    logic [WIDTH-1:0] a_arr [N_REQ];
    logic [WIDTH-1:0] b_arr [N_REQ];
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_flag;

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign a_arr[g] = a_bus[g*WIDTH +: WIDTH];
        assign b_arr[g] = b_bus[g*WIDTH +: WIDTH];
    end

    // Search begins one past the previous winner and wraps, so every requester gets a turn
    always_comb begin
        int               idx;
        logic [N_REQ-1:0] sh;
        idx       = 0;
        sh        = '0;
        win_idx   = last;
        win_found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(last) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            sh = req >> idx;
            if (!win_found && sh[0]) begin
                win_idx   = IDW'(idx);
                win_found = 1'b1;
            end
        end
    end

    assign arb_take = ((state == S_IDLE) || (state == S_DONE)) && win_found;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE,
            S_DONE:  state_nxt = arb_take ? S_GNT : S_IDLE;
            S_GNT:   state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        gnt       = '0;
        res_valid = 1'b0;
        busy      = 1'b0;
        if (state == S_GNT) begin
            gnt = N_REQ'(1) << cur_idx;
        end
        if (state == S_DONE) begin
            res_valid = 1'b1;
        end
        if (state != S_IDLE) begin
            busy = 1'b1;
        end
    end

    // Carry and borrow both fall out of the extra top bit of the widened result
    always_comb begin
        sum_w  = {1'b0, a_q} + {1'b0, b_q};
        diff_w = {1'b0, a_q} - {1'b0, b_q};
        if (op_q) begin
            alu_flag = diff_w[WIDTH];
            alu_res  = diff_w[WIDTH-1:0];
        end else begin
            alu_flag = sum_w[WIDTH];
            alu_res  = sum_w[WIDTH-1:0];
        end
`ifdef ALU_ARB_SAT_EN
        if (alu_flag) begin
            alu_res = op_q ? '0 : '1;
        end
`else
        alu_res = alu_res;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last    <= LAST_RST;
            cur_idx <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            res     <= '0;
            flag    <= 1'b0;
            res_id  <= '0;
        end else begin
            if (arb_take) begin
                last    <= win_idx;
                cur_idx <= win_idx;
            end
            if (state == S_GNT) begin
                a_q  <= a_arr[cur_idx];
                b_q  <= b_arr[cur_idx];
                op_q <= op[cur_idx];
            end
            if (state == S_EXEC) begin
                res    <= alu_res;
                flag   <= alu_flag;
                res_id <= cur_idx;
            end
        end
    end

endmodule
